framebuffer_scanout: RTL and testbench

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

---
 rtl/graphic_pkg.sv | 13 +
 rtl/framebuffer_scanout_if.sv | 29 ++
 rtl/scanout_word_buffer.sv | 48 ++++
 rtl/framebuffer_scanout.sv | 103 ++++++++++
 tb/tb_framebuffer_scanout.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/graphic_pkg.sv
// graphic_pkg: shared constants and types for the Color/Weight SRAM scanout path.
package graphic_pkg;
    localparam int PIX_PER_WORD = 16;
    localparam int RGB_W        = 24;
    localparam int CW_ADDR_W    = 16;
    localparam int CW_WORD_W    = 384;
    localparam int COORD_W      = 12;
    typedef logic [RGB_W-1:0] rgb_t;
    typedef rgb_t [PIX_PER_WORD-1:0] cw_word_t;
    typedef logic [CW_ADDR_W-1:0] cw_addr_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} scan_state_e;
endpackage

// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: frame control, Color/Weight SRAM port and pixel stream of the scanout block.
interface framebuffer_scanout_if;
    import graphic_pkg::*;
    logic                    start;
    logic                    busy;
    logic                    frame_done;
    cw_addr_t                address_sram_CW;
    cw_word_t                read_data_sram_CW;
    logic                    write_enable_sram_CW;
    logic [PIX_PER_WORD-1:0] write_wordmask_sram_CW;
    cw_word_t                write_data_sram_CW;
    logic                    pix_valid;
    logic                    pix_ready;
    rgb_t                    pix_rgb;
    coord_t                  pix_x;
    coord_t                  pix_y;
    logic                    pix_sof;
    logic                    pix_eol;
    modport master (
        input  start, read_data_sram_CW, pix_ready,
        output busy, frame_done, address_sram_CW, write_enable_sram_CW, write_wordmask_sram_CW,
               write_data_sram_CW, pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol
    );
    modport slave (
        output start, read_data_sram_CW, pix_ready,
        input  busy, frame_done, address_sram_CW, write_enable_sram_CW, write_wordmask_sram_CW,
               write_data_sram_CW, pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol
    );
endinterface

// File: rtl/scanout_word_buffer.sv
// scanout_word_buffer: two-entry ping-pong store of SRAM words, presenting one pixel lane per pop.
module scanout_word_buffer
    import graphic_pkg::*;
(
    input  logic     clk,
    input  logic     srst,
    input  logic     load_i,
    input  cw_word_t data_i,
    input  logic     pop_i,
    output logic     valid_o,
    output logic     full_o,
    output rgb_t     rgb_o
);
    cw_word_t   word_q [2];
    logic [1:0] val_q, val_d;
    logic       wp_q, rp_q;
    logic [3:0] lane_q;
    logic       last_lane;

    assign last_lane = lane_q == 4'(PIX_PER_WORD - 1);
    assign valid_o   = val_q[rp_q];
    assign full_o    = &val_q;
    assign rgb_o     = valid_o ? word_q[rp_q][lane_q] : '0;

    // A load only targets a free entry, so release and fill never hit the same index.
    always_comb begin
        val_d = val_q;
        if (pop_i && last_lane) val_d[rp_q] = 1'b0;
        if (load_i) val_d[wp_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            val_q  <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            lane_q <= '0;
        end else begin
            val_q <= val_d;
            if (load_i) wp_q <= ~wp_q;
            if (pop_i) lane_q <= lane_q + 4'd1;
            if (pop_i && last_lane) rp_q <= ~rp_q;
        end
    end

    always_ff @(posedge clk)
        if (load_i) word_q[wp_q] <= data_i;
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: streams one raster frame from the Color/Weight SRAM as a pixel handshake stream.
// Define SCANOUT_CLEAR_EN to write CLEAR_COLOR back over each word in the cycle after it is read.
module framebuffer_scanout
    import graphic_pkg::*;
#(
    parameter int   H_RES       = 640,
    parameter int   V_RES       = 480,
    parameter rgb_t CLEAR_COLOR = 24'h000000
) (
    input logic                   clk,
    input logic                   srst,
    framebuffer_scanout_if.master bus
);
    localparam int       WORDS     = H_RES * V_RES / PIX_PER_WORD;
    localparam cw_addr_t LAST_ADDR = cw_addr_t'(WORDS - 1);
    localparam coord_t   X_LAST    = coord_t'(H_RES - 1);
    localparam coord_t   Y_LAST    = coord_t'(V_RES - 1);

    scan_state_e state_q, state_d;
    cw_addr_t    fetch_addr_q, addr_q;
    logic        rd_pend_q, fetch_done_q, frame_done_q;
    coord_t      x_q, y_q;
    logic        issue, hs, last_hs, buf_valid, buf_full, wr_now;
    rgb_t        buf_rgb;

    scanout_word_buffer u_buf (
        .clk     (clk),
        .srst    (srst),
        .load_i  (rd_pend_q),
        .data_i  (bus.read_data_sram_CW),
        .pop_i   (hs),
        .valid_o (buf_valid),
        .full_o  (buf_full),
        .rgb_o   (buf_rgb)
    );

    always_ff @(posedge clk)
        if (srst) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PRIME;
            PRIME:   if (rd_pend_q) state_d = STREAM;
            STREAM:  if (fetch_done_q) state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One read in flight at most; a read is only launched into a buffer that is already free.
    always_comb begin
        issue   = (state_q == PRIME || state_q == STREAM) && !fetch_done_q && !rd_pend_q && !buf_full;
        hs      = buf_valid && bus.pix_ready;
        last_hs = hs && x_q == X_LAST && y_q == Y_LAST;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fetch_addr_q <= '0;
            addr_q       <= '0;
            rd_pend_q    <= 1'b0;
            fetch_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            rd_pend_q    <= issue;
            frame_done_q <= state_q == DRAIN && last_hs;
            if (state_q == IDLE && bus.start) begin
                fetch_addr_q <= '0;
                fetch_done_q <= 1'b0;
            end else if (issue) begin
                addr_q       <= fetch_addr_q;
                fetch_addr_q <= fetch_addr_q + 1'b1;
                fetch_done_q <= fetch_addr_q == LAST_ADDR;
            end
            if (hs) x_q <= x_q == X_LAST ? '0 : x_q + 1'b1;
            if (hs && x_q == X_LAST) y_q <= y_q == Y_LAST ? '0 : y_q + 1'b1;
        end
    end

`ifdef SCANOUT_CLEAR_EN
    // Write-back shares the read's data-return cycle; reset suppresses it at once.
    assign wr_now = rd_pend_q && !srst;
`else
    assign wr_now = 1'b0;
`endif

    assign bus.busy                   = state_q != IDLE;
    assign bus.frame_done             = frame_done_q;
    assign bus.address_sram_CW        = issue ? fetch_addr_q : addr_q;
    assign bus.write_enable_sram_CW   = !wr_now;
    assign bus.write_wordmask_sram_CW = wr_now ? '0 : '1;
    assign bus.write_data_sram_CW     = wr_now ? {PIX_PER_WORD{CLEAR_COLOR}} : '0;
    assign bus.pix_valid              = buf_valid;
    assign bus.pix_rgb                = buf_rgb;
    assign bus.pix_x                  = x_q;
    assign bus.pix_y                  = y_q;
    assign bus.pix_sof                = buf_valid && x_q == '0 && y_q == '0;
    assign bus.pix_eol                = buf_valid && x_q == X_LAST;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed frames against a raster-order pixel model and an SRAM model.
module tb_framebuffer_scanout;
    import graphic_pkg::*;
    localparam int   H     = 32;
    localparam int   V     = 2;
    localparam int   WORDS = H * V / 16;
    localparam int   NPIX  = H * V;
    localparam rgb_t CC    = 24'h102030;

    logic clk = 1'b0;
    logic srst = 1'b1;
    int total = 0, bad = 0, exp_n = 0, frames = 0, wr_cnt = 0, lat, f0;
    bit chk = 0, gap_chk = 0, rnd = 0, rdy_lvl = 0, clr_req = 0, init_req = 1, stalled = 0;
    logic [49:0] held;
    cw_word_t mem [WORDS];

    framebuffer_scanout_if bus();
    framebuffer_scanout #(.H_RES(H), .V_RES(V), .CLEAR_COLOR(CC)) dut (.clk(clk), .srst(srst), .bus(bus));

    always #5 clk = ~clk;

    wire [49:0] pix_bus = {bus.pix_rgb, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};

    function automatic rgb_t exp_rgb(int n);
        int word = (n / H) * (H / 16) + (n % H) / 16;
        return {12'(word), 12'(n % 16)};
    endfunction

    function automatic int widx(cw_addr_t a);
        return int'(a) % WORDS;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic clr_frame;
        clr_req  = 1;
        init_req = 1;
        tick();
        clr_req  = 0;
        init_req = 0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!bus.frame_done && n < limit) begin
            tick();
            n++;
        end
        check("frame_done_seen", bus.frame_done, 1);
    endtask

    task automatic wait_pix(input int k);
        int n = 0;
        while (exp_n < k && n < 500) begin
            tick();
            n++;
        end
        check("reach_pixel", exp_n, k);
    endtask

    task automatic measure_latency;
        lat = 1;
        while (!bus.pix_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("first_valid_latency", lat, 3);
    endtask

    task automatic reset_vals(string tag);
        check($sformatf("%s_ctl", tag), {bus.busy, bus.frame_done, bus.pix_valid, bus.pix_sof, bus.pix_eol}, 0);
        check($sformatf("%s_sram", tag), {bus.address_sram_CW, bus.write_enable_sram_CW, bus.write_wordmask_sram_CW},
              {16'h0, 1'b1, 16'hFFFF});
        check($sformatf("%s_wdata", tag), |bus.write_data_sram_CW, 0);
        check($sformatf("%s_pix", tag), {bus.pix_rgb, bus.pix_x, bus.pix_y}, 0);
    endtask

    // SRAM: registered read, masked write, image reloaded on request.
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < WORDS; k++)
                for (int i = 0; i < 16; i++) mem[k][i] <= {12'(k), 12'(i)};
        end else if (!bus.write_enable_sram_CW) begin
            for (int i = 0; i < 16; i++)
                if (!bus.write_wordmask_sram_CW[i]) mem[widx(bus.address_sram_CW)][i] <= bus.write_data_sram_CW[i];
        end
        if (bus.write_enable_sram_CW) bus.read_data_sram_CW <= mem[widx(bus.address_sram_CW)];
    end

    initial forever begin
        bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : rdy_lvl;
        @(posedge clk);
        #1;
    end

    always @(negedge clk) if (!srst) begin
        check("addr_range", bus.address_sram_CW < WORDS, 1);
        if (bus.write_enable_sram_CW)
            check("idle_wr_bus", {bus.write_wordmask_sram_CW, |bus.write_data_sram_CW}, {16'hFFFF, 1'b0});
        else begin
            wr_cnt++;
            check("wr_cycle", {bus.write_wordmask_sram_CW, bus.write_data_sram_CW == {16{CC}}}, {16'h0, 1'b1});
        end
        if (bus.frame_done) frames++;
    end

    // Pixel model: pixel n of the frame sits at (n%H, n/H) and comes from word y*(H/16)+x/16, lane x%16.
    always @(negedge clk) begin
        if (clr_req) begin
            exp_n   = 0;
            stalled = 0;
        end else if (chk) begin
            if (bus.pix_valid) begin
                check("pixel", pix_bus, {exp_rgb(exp_n), 12'(exp_n % H), 12'(exp_n / H), exp_n == 0, exp_n % H == H - 1});
                if (stalled) check("stall_hold", pix_bus, held);
                stalled = !bus.pix_ready;
                held = pix_bus;
                if (bus.pix_ready) exp_n++;
            end else begin
                if (stalled) check("stall_valid", 0, 1);
                if (gap_chk && exp_n > 0 && exp_n < NPIX) check("bubble", 0, 1);
                stalled = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        tick(3);
        srst = 1'b0;
        init_req = 0;
        reset_vals("reset");
        // Frame 1: ready held high, literal pixels pin the model.
        rdy_lvl = 1;
        gap_chk = 1;
        chk = 1;
        clr_frame();
        pulse_start();
        check("busy_on", bus.busy, 1);
        measure_latency();
        check("pix0_lit", {bus.pix_rgb, bus.pix_sof, bus.pix_x, bus.pix_y}, {24'h000000, 1'b1, 12'd0, 12'd0});
        tick(17);
        check("pix17_lit", {bus.pix_rgb, bus.pix_x, bus.pix_y}, {24'h001001, 12'd17, 12'd0});
        tick(14);
        check("pix31_eol", {bus.pix_eol, bus.pix_x}, {1'b1, 12'd31});
        tick();
        check("pix32_wrap", {bus.pix_rgb, bus.pix_x, bus.pix_y, bus.pix_eol}, {24'h002000, 12'd0, 12'd1, 1'b0});
        wait_done(200);
        check("busy_off_at_done", bus.busy, 0);
        tick();
        check("done_pulse", {bus.frame_done, 32'(frames)}, {1'b0, 32'd1});
        check("pix_count1", exp_n, NPIX);
`ifdef SCANOUT_CLEAR_EN
        check("clear_writes", wr_cnt, WORDS);
        for (int k = 0; k < WORDS; k++) check($sformatf("cleared_word%0d", k), mem[k] == {16{CC}}, 1);
`endif
        // Frame 2: random backpressure.
        rnd = 1;
        gap_chk = 0;
        clr_frame();
        pulse_start();
        wait_done(2000);
        tick();
        check("pix_count2", exp_n, NPIX);
        check("frames2", frames, 2);
        rnd = 0;
        // Frame 3: a second start mid-frame is ignored.
        gap_chk = 1;
        clr_frame();
        f0 = frames;
        pulse_start();
        wait_pix(10);
        pulse_start();
        wait_done(200);
        tick(20);
        check("one_done", frames - f0, 1);
        check("busy_idle_after", bus.busy, 0);
        check("pix_count3", exp_n, NPIX);
        // Frame 4: reset at pixel 20, then a clean restart.
        clr_frame();
        pulse_start();
        wait_pix(20);
        chk = 0;
        srst = 1'b1;
        tick();
        reset_vals("abort");
        srst = 1'b0;
        clr_frame();
        chk = 1;
        pulse_start();
        check("restart_addr", {bus.address_sram_CW, bus.write_enable_sram_CW}, {16'h0, 1'b1});
        measure_latency();
        check("restart_pix0", {bus.pix_sof, bus.pix_x, bus.pix_y}, {1'b1, 12'd0, 12'd0});
        wait_done(200);
        tick();
        check("pix_count4", exp_n, NPIX);
`ifndef SCANOUT_CLEAR_EN
        check("we_never_low", wr_cnt, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
